// File: rtl/dlsc_pcie_s6_outbound_encode.sv
// Outbound memory request TLP encoder: packs a 3DW/4DW header and byte-swapped payload onto a 32-bit TX stream.
// Optional DLSC_PCIE_S6_OUTBOUND_AUTOTAG_EN: reads take tags from an internal 5-bit counter, writes use tag 0.
module dlsc_pcie_s6_outbound_encode #(
    parameter int ADDR = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     cfg_id,
    output logic            tlp_h_ready,
    input  logic            tlp_h_valid,
    input  logic            tlp_h_write,
    input  logic [ADDR-3:0] tlp_h_addr,
    input  logic [9:0]      tlp_h_len,
    input  logic [3:0]      tlp_h_be_first,
    input  logic [3:0]      tlp_h_be_last,
    input  logic [7:0]      tlp_h_tag,
    output logic            tlp_d_ready,
    input  logic            tlp_d_valid,
    input  logic [31:0]     tlp_d_data,
    input  logic            tx_ready,
    output logic            tx_valid,
    output logic [31:0]     tx_data,
    output logic            tx_last
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_H0,
        ST_H1,
        ST_H2,
        ST_H3,
        ST_DATA
    } state_t;

    state_t      state_q;
    logic [31:0] h0_q, h1_q, h2_q, h3_q;
    logic [31:0] h0_d, h1_d, h2_d, h3_d;
    logic        fmt64_q, fmt64_d;
    logic        write_q;
    logic [10:0] cnt_q, cnt_d;
    logic [63:0] addr64;
    logic [7:0]  tag_d;
    logic [3:0]  be_last_d;

`ifdef DLSC_PCIE_S6_OUTBOUND_AUTOTAG_EN
    logic [4:0]  tag_cnt_q;
`endif

    // Header words are built combinationally from the request and captured at accept
    always_comb begin
        addr64            = '0;
        addr64[ADDR-1:0]  = {tlp_h_addr, 2'b00};
        fmt64_d           = |addr64[63:32];
        cnt_d             = {(tlp_h_len == 10'd0), tlp_h_len};
`ifdef DLSC_PCIE_S6_OUTBOUND_AUTOTAG_EN
        tag_d             = tlp_h_write ? 8'h00 : {3'b000, tag_cnt_q};
`else
        tag_d             = tlp_h_tag;
`endif
        be_last_d         = (tlp_h_len == 10'd1) ? 4'h0 : tlp_h_be_last;
        h0_d              = {1'b0, tlp_h_write, fmt64_d, 5'b00000, 1'b0, 3'b000, 4'b0000,
                             1'b0, 1'b0, 2'b00, 2'b00, tlp_h_len};
        h1_d              = {cfg_id, tag_d, be_last_d, tlp_h_be_first};
        h3_d              = {addr64[31:2], 2'b00};
        h2_d              = fmt64_d ? addr64[63:32] : h3_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            h0_q      <= '0;
            h1_q      <= '0;
            h2_q      <= '0;
            h3_q      <= '0;
            fmt64_q   <= 1'b0;
            write_q   <= 1'b0;
            cnt_q     <= '0;
`ifdef DLSC_PCIE_S6_OUTBOUND_AUTOTAG_EN
            tag_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tlp_h_valid) begin
                        h0_q    <= h0_d;
                        h1_q    <= h1_d;
                        h2_q    <= h2_d;
                        h3_q    <= h3_d;
                        fmt64_q <= fmt64_d;
                        write_q <= tlp_h_write;
                        cnt_q   <= cnt_d;
                        state_q <= ST_H0;
`ifdef DLSC_PCIE_S6_OUTBOUND_AUTOTAG_EN
                        if (!tlp_h_write) tag_cnt_q <= tag_cnt_q + 5'd1;
`endif
                    end
                end
                ST_H0: if (tx_ready) state_q <= ST_H1;
                ST_H1: if (tx_ready) state_q <= ST_H2;
                ST_H2: if (tx_ready) state_q <= fmt64_q ? ST_H3 : (write_q ? ST_DATA : ST_IDLE);
                ST_H3: if (tx_ready) state_q <= write_q ? ST_DATA : ST_IDLE;
                ST_DATA: begin
                    if (tlp_d_valid && tx_ready) begin
                        cnt_q <= cnt_q - 11'd1;
                        if (cnt_q == 11'd1) state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Payload passes straight through so the core's backpressure reaches the source without a skid buffer
    always_comb begin
        tlp_h_ready = 1'b0;
        tlp_d_ready = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = '0;
        tx_last     = 1'b0;
        case (state_q)
            ST_IDLE: tlp_h_ready = !rst;
            ST_H0: begin
                tx_valid = 1'b1;
                tx_data  = h0_q;
            end
            ST_H1: begin
                tx_valid = 1'b1;
                tx_data  = h1_q;
            end
            ST_H2: begin
                tx_valid = 1'b1;
                tx_data  = h2_q;
                tx_last  = !fmt64_q && !write_q;
            end
            ST_H3: begin
                tx_valid = 1'b1;
                tx_data  = h3_q;
                tx_last  = !write_q;
            end
            ST_DATA: begin
                tlp_d_ready = tx_ready;
                tx_valid    = tlp_d_valid;
                tx_data     = {tlp_d_data[7:0], tlp_d_data[15:8], tlp_d_data[23:16], tlp_d_data[31:24]};
                tx_last     = (cnt_q == 11'd1);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_encode.sv
// Randomized bench for dlsc_pcie_s6_outbound_encode (ADDR=64); expected TX stream comes from a queue-based TLP model.
module tb_dlsc_pcie_s6_outbound_encode;

    localparam int ADDR = 64;
    localparam int TMO  = 4000;

    logic            clk = 1'b0;
    logic            rst;
    logic [15:0]     cfg_id;
    logic            tlp_h_ready;
    logic            tlp_h_valid;
    logic            tlp_h_write;
    logic [ADDR-3:0] tlp_h_addr;
    logic [9:0]      tlp_h_len;
    logic [3:0]      tlp_h_be_first;
    logic [3:0]      tlp_h_be_last;
    logic [7:0]      tlp_h_tag;
    logic            tlp_d_ready;
    logic            tlp_d_valid;
    logic [31:0]     tlp_d_data;
    logic            tx_ready;
    logic            tx_valid;
    logic [31:0]     tx_data;
    logic            tx_last;

    dlsc_pcie_s6_outbound_encode #(.ADDR(ADDR)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_id         (cfg_id),
        .tlp_h_ready    (tlp_h_ready),
        .tlp_h_valid    (tlp_h_valid),
        .tlp_h_write    (tlp_h_write),
        .tlp_h_addr     (tlp_h_addr),
        .tlp_h_len      (tlp_h_len),
        .tlp_h_be_first (tlp_h_be_first),
        .tlp_h_be_last  (tlp_h_be_last),
        .tlp_h_tag      (tlp_h_tag),
        .tlp_d_ready    (tlp_d_ready),
        .tlp_d_valid    (tlp_d_valid),
        .tlp_d_data     (tlp_d_data),
        .tx_ready       (tx_ready),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_last        (tx_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } dw_t;

    dw_t         exp_q[$];
    logic [31:0] pay_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          stall_pct = 0;
    logic [4:0]  mtag = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic give_up(input string tag, input int waited);
        chk(tag, waited, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    // Reference TLP: header fields in PCIe order, then payload DWs byte-reversed
    task automatic build_exp(input bit wr, input logic [63:0] a, input logic [9:0] len,
                             input logic [3:0] bf, input logic [3:0] bl, input logic [7:0] tg,
                             input logic [15:0] cid);
        dw_t         e;
        logic [31:0] h0;
        bit          four_dw;
        int          n;
        four_dw = (a[63:32] != 0);
        n       = (len == 0) ? 1024 : int'(len);
        h0      = 32'(len) + (wr ? 32'h4000_0000 : 0) + (four_dw ? 32'h2000_0000 : 0);
        e.l = 0; e.d = h0;                                        exp_q.push_back(e);
        e.d = {cid, tg, (len == 1) ? 4'h0 : bl, bf};              exp_q.push_back(e);
        if (four_dw) begin
            e.d = a[63:32];                                       exp_q.push_back(e);
        end
        e.d = a[31:0] & 32'hFFFF_FFFC; e.l = !wr;                 exp_q.push_back(e);
        if (wr) begin
            for (int i = 0; i < n; i++) begin
                e.d = {<<8{pay_q[i]}};
                e.l = (i == n - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_reset_abort();
        rst         = 1'b1;
        tlp_d_valid = 1'b1;
        exp_q.delete();
        mtag        = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_h_ready", tlp_h_ready, 1);
        @(posedge clk); #1;
        tlp_d_valid = 1'b0;
    endtask

    task automatic send(input bit wr, input logic [63:0] a, input logic [9:0] len,
                        input logic [3:0] bf, input logic [3:0] bl, input logic [7:0] tg,
                        input logic [15:0] cid, input int stall, input int abort_at);
        int         n;
        int         t;
        logic [7:0] etag;
        n         = (len == 0) ? 1024 : int'(len);
        stall_pct = stall;
        if (!wr || pay_q.size() != n) begin
            pay_q.delete();
            if (wr) for (int i = 0; i < n; i++) pay_q.push_back($urandom);
        end
`ifdef DLSC_PCIE_S6_OUTBOUND_AUTOTAG_EN
        if (wr) etag = 8'h00;
        else begin
            etag = {3'b000, mtag};
            mtag = mtag + 5'd1;
        end
`else
        etag = tg;
`endif
        build_exp(wr, a, len, bf, bl, etag, cid);

        tlp_h_valid    = 1'b1;
        tlp_h_write    = wr;
        tlp_h_addr     = a[63:2];
        tlp_h_len      = len;
        tlp_h_be_first = bf;
        tlp_h_be_last  = bl;
        tlp_h_tag      = tg;
        cfg_id         = cid;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (tlp_h_ready) break;
            if (++t > TMO) give_up("hdr_accept_timeout", t);
        end
        @(posedge clk); #1;
        // header inputs and cfg_id must already be captured
        tlp_h_valid    = 1'b0;
        cfg_id         = 16'($urandom);
        tlp_h_addr     = {$urandom, $urandom};
        tlp_h_len      = 10'($urandom);
        tlp_h_tag      = 8'($urandom);
        tlp_h_be_first = 4'($urandom);
        tlp_h_be_last  = 4'($urandom);
        tlp_h_write    = 1'($urandom);
        if (!wr) begin
            tlp_d_valid = 1'b1;
            tlp_d_data  = $urandom;
        end
        @(negedge clk);
        chk("h0_latency", tx_valid, 1);
        @(posedge clk); #1;

        if (wr) begin
            for (int i = 0; i < n; i++) begin
                if (i == abort_at) begin
                    do_reset_abort();
                    pay_q.delete();
                    return;
                end
                if (stall > 0) begin
                    repeat ($urandom_range(2)) begin
                        tlp_d_valid = 1'b0;
                        tlp_d_data  = $urandom;
                        @(posedge clk); #1;
                    end
                end
                tlp_d_valid = 1'b1;
                tlp_d_data  = pay_q[i];
                t = 0;
                while (1) begin
                    @(negedge clk);
                    if (tlp_d_ready) break;
                    if (++t > TMO) give_up("payload_timeout", t);
                end
                @(posedge clk); #1;
            end
            tlp_d_valid = 1'b1;
            tlp_d_data  = $urandom;
        end

        t = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            if (!wr) chk("rd_no_dready", tlp_d_ready, 0);
            if (++t > TMO) give_up("tlp_done_timeout", t);
        end
        @(negedge clk);
        chk("h_ready_after", tlp_h_ready, 1);
        chk("d_ready_idle", tlp_d_ready, 0);
        @(posedge clk); #1;
        tlp_d_valid = 1'b0;
        pay_q.delete();
    endtask

    // TX monitor: order, tx_last placement, hold-during-stall, no header accept while busy
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    dw_t         got_e;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("stall_hold", {tx_valid, tx_data}, {1'b1, prev_data});
            if (tx_valid) chk("h_ready_busy", tlp_h_ready, 0);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_tx", exp_q.size(), 1);
                end else begin
                    got_e = exp_q.pop_front();
                    chk("tx_data", tx_data, got_e.d);
                    chk("tx_last", tx_last, got_e.l);
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            tx_ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end

    initial begin
        logic [63:0] a;
        rst            = 1'b1;
        cfg_id         = '0;
        tlp_h_valid    = 1'b0;
        tlp_h_write    = 1'b0;
        tlp_h_addr     = '0;
        tlp_h_len      = '0;
        tlp_h_be_first = '0;
        tlp_h_be_last  = '0;
        tlp_h_tag      = '0;
        tlp_d_valid    = 1'b0;
        tlp_d_data     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_tx_last", tx_last, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_h_ready", tlp_h_ready, 0);
        chk("reset_d_ready", tlp_d_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_h_ready", tlp_h_ready, 1);
        @(posedge clk); #1;

        // directed cases
        send(0, 64'h0000_0000_1234_5678, 10'd4, 4'hF, 4'hF, 8'h03, 16'h0100, 0, -1);
        pay_q = '{32'hAABB_CCDD, 32'h1122_3344};
        send(1, 64'h0000_0000_0000_1000, 10'd2, 4'hF, 4'h3, 8'h11, 16'h0100, 0, -1);
        send(1, 64'h0000_0001_0000_0010, 10'd1, 4'hF, 4'h5, 8'h22, 16'h0100, 0, -1);
        send(1, 64'h0000_0000_0000_0010, 10'd1, 4'hF, 4'h5, 8'h23, 16'h0100, 0, -1);
        send(0, 64'hFFFF_FFFF_FFFF_FFF0, 10'd1, 4'h1, 4'h8, 8'hC4, 16'hBEEF, 30, -1);
        send(1, 64'h0000_0000_0000_2000, 10'd0, 4'hF, 4'hF, 8'h44, 16'h0203, 0, -1);
        send(1, 64'h0000_0000_0000_3000, 10'd8, 4'hF, 4'hF, 8'h55, 16'h0304, 40, -1);
        send(1, 64'h0000_0000_0000_4000, 10'd8, 4'hF, 4'hF, 8'h66, 16'h0405, 40, 4);

        // read-tag sequence with one write after the fifth read
        for (int i = 0; i < 34; i++) begin
            a = {32'h0, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
            if (i == 5) send(1, a, 10'd3, 4'hF, 4'hF, 8'($urandom), 16'h0100, 20, -1);
            else        send(0, a, 10'd2, 4'hF, 4'hF, 8'($urandom), 16'h0100, 20, -1);
        end

        // random mix
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(1) == 1) ? {$urandom, $urandom} : {32'h0, $urandom};
            a[1:0] = 2'b00;
            send(1'($urandom), a, 10'($urandom_range(1, 16)), 4'($urandom), 4'($urandom),
                 8'($urandom), 16'($urandom), $urandom_range(0, 50), -1);
        end

        chk("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dlsc_pcie_s6_outbound_encode.md
Name: dlsc_pcie_s6_outbound_encode

Overview:
Outbound request TLP encoder for the Spartan-6 PCIe endpoint. It takes a memory read or write request (header plus write payload) from the outbound master logic and emits a properly formatted 3DW or 4DW request TLP as a 32-bit DW stream toward the core's TX port. It performs format selection (32/64-bit), header packing, payload length counting and payload byte swapping. It is the transmit-side counterpart of the inbound request decoder.

Parameters:
ADDR, 32, request address width in bits (legal 32..64); request address carried as [ADDR-1:2]

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
cfg_id  input  16  requester ID {bus,dev,fn}, sampled at header accept
tlp_h_ready  output  1  header accept
tlp_h_valid  input  1  header valid
tlp_h_write  input  1  1=memory write (posted), 0=memory read
tlp_h_addr  input  ADDR-2  DW address [ADDR-1:2]
tlp_h_len  input  10  length in DW; 0 = 1024
tlp_h_be_first  input  4  first DW byte enables
tlp_h_be_last  input  4  last DW byte enables
tlp_h_tag  input  8  request tag
tlp_d_ready  output  1  payload accept
tlp_d_valid  input  1  payload valid
tlp_d_data  input  32  payload DW, little-endian byte order
tx_ready  input  1  TX accept
tx_valid  output  1  TX valid
tx_data  output  32  TX DW, PCIe byte order
tx_last  output  1  final DW of TLP

Behaviour:
- States: ST_IDLE, ST_H0, ST_H1, ST_H2, ST_H3, ST_DATA. Reset: state ST_IDLE; tx_valid=0, tx_last=0, tx_data=0, tlp_h_ready=0, tlp_d_ready=0; length counter 0.
- tlp_h_ready=1 only in ST_IDLE and not in rst. On tlp_h_valid&&tlp_h_ready, all header inputs and cfg_id are registered; next state ST_H0. First header DW on tx_valid the cycle after accept.
- fmt_64 = (ADDR>32) && (tlp_h_addr[ADDR-1:32] != 0). Addresses below 4GB always use 3DW format.
- H0 = {1'b0, write, fmt_64, 5'b00000 (MEM), 1'b0, TC=3'b000, 4'b0, TD=0, EP=0, attr=2'b00, 2'b00, len[9:0]}.
- H1 = {cfg_id, tag, be_last', be_first}; be_last' = 4'h0 when len==1, else tlp_h_be_last.
- H2 = fmt_64 ? addr[63:32] (upper bits above ADDR-1 zero) : {addr[31:2],2'b00}. H3 (fmt_64 only) = {addr[31:2],2'b00}.
- In ST_H0..ST_H3 tx_valid=1; state advances only on tx_ready. tx_data held stable while tx_valid && !tx_ready.
- After last header DW: write -> ST_DATA; read -> ST_IDLE with tx_last=1 on that DW.
- ST_DATA: tlp_d_ready = tx_ready; tx_valid = tlp_d_valid; tx_data = {d[7:0], d[15:8], d[23:16], d[31:24]}. An 11-bit counter is loaded with len (0 maps to 1024) at header accept and decremented per accepted data DW. tx_last=1 when counter==1; on that transfer the state goes to ST_IDLE.
- Payload DWs beyond len are never accepted (tlp_d_ready=0 outside ST_DATA). No payload is consumed for reads.
- Back-to-back: a new header is accepted in ST_IDLE only, so there is a one-cycle bubble between TLPs.
- rst mid-TLP: the next cycle is ST_IDLE with tx_valid=0. The partial TLP is abandoned, and the downstream core is reset with the same rst.

Optional Feature:
DLSC_PCIE_S6_OUTBOUND_AUTOTAG_EN
- Defined: tlp_h_tag is ignored.
  - Reads take the tag from an internal 5-bit counter, zero-extended to 8 bits. The counter resets to 0, increments on each accepted read header, and wraps 31->0.
  - Writes send tag 0 and leave the counter unchanged.
- Undefined: tag = registered tlp_h_tag; no counter.

Test Plan:
1. 32-bit read: addr 0x12345678 (DW 0x048D159E), len 4, be F/F, tag 0x03, cfg_id 0x0100 -> tx 0x00000004, 0x010003FF, 0x12345678; tx_last on the 3rd DW; tlp_d_ready never asserted.
2. 32-bit write: addr 0x00001000, len 2, be F/3, data 0xAABBCCDD, 0x11223344 -> H0 0x40000002, H1 0x0100xx3F, H2 0x00001000, then 0xDDCCBBAA, 0x44332211 with tx_last on the final DW.
3. ADDR=64 write: addr 0x1_00000010, len 1, be_first F, be_last 5 -> H0 0x60000001, H1 low byte 0x0F, H2 0x00000001, H3 0x00000010, one data DW with tx_last. Repeat with addr 0x0_00000010 -> 3DW, H0 0x40000001.
4. Write with len 0 -> exactly 1024 payload DWs; tx_last only on the 1024th; tlp_h_ready stays low until the cycle after it.
5. Random tx_ready/tlp_d_valid stalls on a len-8 write -> tx_data stable during every stall; order intact. Assert rst mid-payload -> tx_valid=0 next cycle, tlp_h_ready=1 the cycle after rst deasserts.
6. AUTOTAG_EN: 33 reads with a write inserted after the 5th -> read tags 0..31 then 0; the write carries tag 0; the counter is unaffected by the write.
